// File: rtl/lunxun30_dispatch.sv
// Receive-side dispatcher: checks aggregated 64-bit words, buffers good ones in a FIFO and
// hands each payload back to its channel (1..NCH) with an in-order valid/ready handshake.
module lunxun30_dispatch #(
    parameter int unsigned NCH        = 30,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  MARKER     = 8'h5A
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            data_valid,
    input  logic [63:0]     up_data,
    input  logic [NCH-1:0]  ch_ready,
    output logic [NCH-1:0]  ch_valid,
    output logic [31:0]     ch_data,
    output logic [4:0]      fifo_level,
    output logic [15:0]     ovf_cnt,
    output logic [15:0]     bad_cnt,
    output logic            busy
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned IDW = 6;
    localparam int unsigned DW  = 32;
    localparam int unsigned EW  = IDW + DW;

    typedef enum logic {IDLE, PRESENT} state_e;

    state_e          state_q, state_d;
    logic            in_valid_q, in_valid_d;
    logic [7:0]      in_marker_q, in_marker_d;
    logic [IDW-1:0]  in_id_q, in_id_d;
    logic [DW-1:0]   in_pay_q, in_pay_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NCH-1:0]  ch_valid_q, ch_valid_d;
    logic [DW-1:0]   ch_data_q, ch_data_d;
    logic [4:0]      fifo_level_q, fifo_level_d;
    logic [15:0]     ovf_cnt_q, ovf_cnt_d, bad_cnt_q, bad_cnt_d;
    logic            busy_q, busy_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic [PW-1:0]   level;
    logic [PW-1:0]   level_nxt;
    logic [EW-1:0]   head;
    logic            empty, full, transfer, pop, push, good;
    logic            unused_rsvd;

    assign unused_rsvd = ^up_data[55:38];

    // Ingress check, FIFO bookkeeping and dispatch FSM next-state
    always_comb begin
        state_d      = state_q;
        in_valid_d   = data_valid;
        in_marker_d  = up_data[63:56];
        in_id_d      = up_data[37:32];
        in_pay_d     = up_data[31:0];
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ch_valid_d   = ch_valid_q;
        ch_data_d    = ch_data_q;
        ovf_cnt_d    = ovf_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        push         = 1'b0;

        level    = wr_ptr_q - rd_ptr_q;
        empty    = (level == '0);
        full     = (level == PW'(FIFO_DEPTH));
        head     = mem_q[rd_ptr_q[AW-1:0]];
        transfer = (state_q == PRESENT) && (|(ch_valid_q & ch_ready));
        pop      = !empty && ((state_q == IDLE) || transfer);
        good     = (in_marker_q == MARKER) && (in_id_q != '0) && (in_id_q <= IDW'(NCH));

        // Bad words never reach the overflow check
        if (in_valid_q) begin
            if (!good) begin
                if (bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
            end else if (full && !pop) begin
                if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
            end else begin
                push = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pop) state_d = PRESENT;
            end
            PRESENT: begin
                if (transfer && !pop) begin
                    ch_valid_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            ch_valid_d = NCH'(1) << (head[EW-1:DW] - IDW'(1));
            ch_data_d  = head[DW-1:0];
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);

        level_nxt    = wr_ptr_d - rd_ptr_d;
        fifo_level_d = 5'(level_nxt);
        busy_d       = (level_nxt != '0) || (|ch_valid_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_valid_q   <= 1'b0;
            in_marker_q  <= '0;
            in_id_q      <= '0;
            in_pay_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ch_valid_q   <= '0;
            ch_data_q    <= '0;
            fifo_level_q <= '0;
            ovf_cnt_q    <= '0;
            bad_cnt_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_valid_q   <= in_valid_d;
            in_marker_q  <= in_marker_d;
            in_id_q      <= in_id_d;
            in_pay_q     <= in_pay_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ch_valid_q   <= ch_valid_d;
            ch_data_q    <= ch_data_d;
            fifo_level_q <= fifo_level_d;
            ovf_cnt_q    <= ovf_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            busy_q       <= busy_d;
        end
    end

    // Storage needs no reset: pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_id_q, in_pay_q};
    end

    assign ch_valid   = ch_valid_q;
    assign ch_data    = ch_data_q;
    assign fifo_level = fifo_level_q;
    assign ovf_cnt    = ovf_cnt_q;
    assign bad_cnt    = bad_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lunxun30_dispatch.sv
// Bench for lunxun30_dispatch: directed scenarios plus random traffic, every cycle compared
// against a queue-based transaction model of the ingress/FIFO/dispatch rules.
module tb_lunxun30_dispatch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_valid;
    logic [63:0] up_data;
    logic [29:0] ch_ready;
    logic [29:0] ch_valid;
    logic [31:0] ch_data;
    logic [4:0]  fifo_level;
    logic [15:0] ovf_cnt, bad_cnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: ingress slot, buffered entries, presented word, counters
    logic        m_inv;
    logic [63:0] m_inw;
    logic [37:0] m_q[$];
    logic        m_pv;
    int          m_pid;
    logic [31:0] m_pdata;
    int          m_ovf, m_bad;

    lunxun30_dispatch dut (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .up_data(up_data),
        .ch_ready(ch_ready), .ch_valid(ch_valid), .ch_data(ch_data),
        .fifo_level(fifo_level), .ovf_cnt(ovf_cnt), .bad_cnt(bad_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] mk_marker, input int id, input logic [31:0] pay);
        logic [5:0] id6;
        id6 = 6'(id);
        return {mk_marker, 18'h0, id6, pay};
    endfunction

    task automatic model_reset();
        m_inv = 1'b0; m_inw = '0; m_q.delete();
        m_pv = 1'b0; m_pid = 1; m_pdata = '0; m_ovf = 0; m_bad = 0;
    endtask

    // One clock edge worth of behaviour, evaluated on the values in place before the edge
    task automatic model_step();
        bit   xfer, do_pop, was_full;
        int   id;
        logic [37:0] e;
        xfer     = m_pv && ch_ready[m_pid-1];
        was_full = (m_q.size() == 16);
        do_pop   = (m_q.size() > 0) && (!m_pv || xfer);
        if (do_pop) begin
            e = m_q.pop_front();
            m_pv = 1'b1; m_pid = int'(e[37:32]); m_pdata = e[31:0];
        end else if (xfer) begin
            m_pv = 1'b0;
        end
        if (m_inv) begin
            id = int'(m_inw[37:32]);
            if (m_inw[63:56] != 8'h5A || id < 1 || id > 30) begin
                if (m_bad < 65535) m_bad++;
            end else if (was_full && !do_pop) begin
                if (m_ovf < 65535) m_ovf++;
            end else begin
                m_q.push_back({m_inw[37:32], m_inw[31:0]});
            end
        end
        m_inv = data_valid;
        m_inw = up_data;
    endtask

    task automatic compare_all();
        logic [29:0] ev;
        ev = m_pv ? (30'd1 << (m_pid - 1)) : 30'd0;
        check("ch_valid", 64'(ch_valid), 64'(ev));
        check("ch_data", 64'(ch_data), 64'(m_pdata));
        check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
        check("bad_cnt", 64'(bad_cnt), 64'(m_bad));
        check("busy", 64'(busy), 64'((m_q.size() != 0) || m_pv));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [63:0] w);
        data_valid = 1'b1; up_data = w;
        cycle();
        data_valid = 1'b0; up_data = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0; data_valid = 1'b0; up_data = '0; ch_ready = '1;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        compare_all();

        // Single good word: presented two edges after it is sampled
        data_valid = 1'b1; up_data = mk(8'h5A, 7, 32'h0000_1234);
        cycle();
        data_valid = 1'b0; up_data = '0;
        cycle();
        cycle();
        check("t1_valid", 64'(ch_valid), 64'(30'h0000_0040));
        check("t1_data", 64'(ch_data), 64'h1234);
        cycle();
        check("t1_valid_drop", 64'(ch_valid), 64'h0);
        idle(2);

        // Bad marker, id 0, id 31
        send(mk(8'h00, 3, 32'hAAAA));
        send(mk(8'h5A, 0, 32'hBBBB));
        send(mk(8'h5A, 31, 32'hCCCC));
        idle(3);
        check("t2_bad", 64'(bad_cnt), 64'd3);
        check("t2_level", 64'(fifo_level), 64'd0);

        // Backpressure with overflow
        ch_ready = '0;
        for (int p = 1; p <= 20; p++) send(mk(8'h5A, 1, 32'(p)));
        idle(2);
        check("t3_level", 64'(fifo_level), 64'd16);
        check("t3_ovf", 64'(ovf_cnt), 64'd3);
        check("t3_held", 64'(ch_data), 64'd1);
        // Full FIFO: new word lands in the ingress slot, then pops coincide with its write
        send(mk(8'h5A, 1, 32'd21));
        ch_ready = 30'h1;
        cycle();
        check("t4_ovf", 64'(ovf_cnt), 64'd3);
        check("t4_level", 64'(fifo_level), 64'd16);
        check("t4_data", 64'(ch_data), 64'd2);
        idle(20);
        ch_ready = '1;

        // Mixed channels with channel 2 stalled
        ch_ready = 30'h2000_0000;
        send(mk(8'h5A, 30, 32'h30_0001));
        send(mk(8'h5A, 2, 32'h02_0002));
        send(mk(8'h5A, 30, 32'h30_0003));
        idle(6);
        check("t5_stall_valid", 64'(ch_valid), 64'(30'h2));
        check("t5_stall_data", 64'(ch_data), 64'h02_0002);
        check("t5_waiting", 64'(fifo_level), 64'd1);
        ch_ready = 30'h2000_0002;
        idle(4);
        ch_ready = '1;

        // Reset while words are buffered and presented
        ch_ready = '0;
        for (int p = 0; p < 6; p++) send(mk(8'h5A, 5, 32'(100 + p)));
        idle(2);
        check("t6_level", 64'(fifo_level), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(ch_valid), 64'h0);
        check("t6_rst_data", 64'(ch_data), 64'h0);
        check("t6_rst_level", 64'(fifo_level), 64'h0);
        check("t6_rst_busy", 64'(busy), 64'h0);
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        ch_ready = '1;
        idle(6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r, id;
            logic [7:0] mrk;
            r = int'($urandom_range(0, 99));
            data_valid = (r < 70);
            mrk = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h5A;
            id  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(1, 30));
            up_data = {mrk, 18'($urandom), 6'(id), 32'($urandom)};
            if (i % 400 < 150) ch_ready = 30'($urandom) & 30'($urandom);
            else ch_ready = 30'($urandom) | 30'($urandom);
            cycle();
        end
        data_valid = 1'b0; up_data = '0; ch_ready = '1;
        idle(40);
        check("final_idle_busy", 64'(busy), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
